// File: rtl/mult_pkg.sv
// Shared types and defaults for the iterative shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 32;

endpackage : mult_pkg

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per clock,
// WIDTH iterations per product, truncated result plus overflow flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one shift-and-add iteration per clock, WIDTH clocks total
// DONE  | result presented, held until out_valid && out_ready
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t          state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;

  // FSM and datapath: accumulator is double width so no carry is ever lost,
  // and there is no early exit so every product takes exactly WIDTH clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, in_a};
            mplier <= in_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          // acc is frozen here, so the result stays stable under backpressure
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state and accumulator only; no input feeds
  // any output combinationally.
  always_comb begin
    in_ready   = (state == IDLE);
    busy       = (state == RUN) || (state == DONE);
    out_valid  = (state == DONE);
    out_result = acc[WIDTH-1:0];
    out_ovf    = |acc[2*WIDTH-1:WIDTH];
  end

endmodule : shift_add_mult
